// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: parity modes, FSM encodings
// and the baud divisor helper.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP,
    RX_DONE,
    RX_BRK
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } tx_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: two-flop synchroniser, mid-bit sampling, false-start
// rejection, parity/framing checks and break hold-off.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = PARITY_NONE
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int unsigned   CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    LAST_IDX = 4'(DATA_BITS - 1);

  logic [1:0]           r_sync;
  logic                 w_rxs;
  rx_state_t            r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [3:0]           r_idx, w_idx_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_par, w_par_nxt;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_perr, r_ferr;
  logic                 w_tick, w_load;

  assign w_rxs  = r_sync[1];
  assign w_tick = (r_cnt == LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_load      = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rxs) w_state_nxt = RX_START;
      end
      RX_START: if (r_cnt == HALF) begin
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_par_nxt   = 1'b0;
        w_state_nxt = w_rxs ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (w_tick) begin
        w_cnt_nxt   = '0;
        w_shift_nxt = {w_rxs, r_shift[DATA_BITS-1:1]};
        w_par_nxt   = r_par ^ w_rxs;
        w_idx_nxt   = r_idx + 1'b1;
        if (r_idx == LAST_IDX)
          w_state_nxt = (PARITY != PARITY_NONE) ? RX_PAR : RX_STOP;
      end
      RX_PAR: if (w_tick) begin
        w_cnt_nxt   = '0;
        w_par_nxt   = r_par ^ w_rxs;
        w_state_nxt = RX_STOP;
      end
      RX_STOP: if (w_tick) begin
        w_cnt_nxt   = '0;
        w_load      = 1'b1;
        w_state_nxt = RX_DONE;
      end
      // A low stop bit parks in BRK so a held-low line reports only once.
      RX_DONE: w_state_nxt = r_ferr ? RX_BRK : RX_IDLE;
      RX_BRK:  if (w_rxs) w_state_nxt = RX_IDLE;
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync  <= 2'b11;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_data  <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], rx};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      if (w_load) begin
        r_data <= r_shift;
        r_ferr <= ~w_rxs;
        r_perr <= (PARITY == PARITY_EVEN) ? r_par :
                  (PARITY == PARITY_ODD)  ? ~r_par : 1'b0;
      end
    end
  end

  assign rx_data       = r_data;
  assign rx_valid      = (r_state == RX_DONE);
  assign rx_parity_err = r_perr;
  assign rx_frame_err  = r_ferr;

endmodule

// File: rtl/uart_param.sv
// Parametrised full-duplex UART: transmitter FSM here, receiver in
// uart_rx_core. Single clock domain, synchronous active-high reset.
module uart_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = PARITY_NONE,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 tx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY > PARITY_EVEN ||
      STOP_BITS < 1 || STOP_BITS > 2 || CLKS_PER_BIT < 4) begin : g_bad_cfg
    $error("uart_param: illegal DATA_BITS/PARITY/STOP_BITS/baud configuration");
  end

  localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_IDX  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  tx_state_t            r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [3:0]           r_idx, w_idx_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_par_bit, r_tx, r_done;
  logic                 w_tx_nxt, w_done_nxt, w_accept, w_tick;

  assign w_tick = (r_cnt == LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_done_nxt  = 1'b0;
    w_accept    = 1'b0;
    if (r_state != TX_IDLE) w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;
    case (r_state)
      TX_IDLE: if (tx_start) begin
        w_accept    = 1'b1;
        w_state_nxt = TX_START;
        w_cnt_nxt   = '0;
        w_shift_nxt = tx_data;
      end
      TX_START: if (w_tick) begin
        w_state_nxt = TX_DATA;
        w_idx_nxt   = '0;
      end
      TX_DATA: if (w_tick) begin
        w_shift_nxt = r_shift >> 1;
        w_idx_nxt   = r_idx + 1'b1;
        if (r_idx == LAST_IDX) begin
          w_idx_nxt   = '0;
          w_state_nxt = (PARITY != PARITY_NONE) ? TX_PAR : TX_STOP;
        end
      end
      TX_PAR: if (w_tick) begin
        w_idx_nxt   = '0;
        w_state_nxt = TX_STOP;
      end
      TX_STOP: if (w_tick) begin
        if (r_idx == LAST_STOP) begin
          w_state_nxt = TX_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: w_state_nxt = TX_IDLE;
    endcase

    // Line level is registered from the next state so tx never glitches.
    case (w_state_nxt)
      TX_START: w_tx_nxt = 1'b0;
      TX_DATA:  w_tx_nxt = w_shift_nxt[0];
      TX_PAR:   w_tx_nxt = r_par_bit;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= TX_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_par_bit <= 1'b0;
      r_tx      <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_done  <= w_done_nxt;
      if (w_accept)
        r_par_bit <= (PARITY == PARITY_ODD) ? ~^tx_data : ^tx_data;
    end
  end

  assign tx      = r_tx;
  assign tx_busy = (r_state != TX_IDLE);
  assign tx_done = r_done;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_BITS   (DATA_BITS),
    .PARITY      (PARITY)
  ) u_rx (
    .clock        (clock),
    .reset        (reset),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err (rx_frame_err)
  );

endmodule

// File: tb/tb_uart_param.sv
// Directed bench for uart_param at 10 clocks per bit: 8N1 (tx and driven rx),
// 7E2 loopback, and 8O1 receive-only instances.
module tb_uart_param;

  localparam int unsigned CF = 1000000;
  localparam int unsigned BR = 100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   errors = 0;
  int   checks = 0;

  // 8N1 instance; rx selectable between bench driver and its own tx
  logic       rxd8, loop8, w_rx8, tx8, rx_valid8, perr8, ferr8, tx_start8, busy8, done8;
  logic [7:0] rx_data8, tx_data8;
  assign w_rx8 = loop8 ? tx8 : rxd8;

  uart_param #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut8 (
    .clock(clk), .reset(reset), .rx(w_rx8), .tx(tx8), .rx_data(rx_data8),
    .rx_valid(rx_valid8), .rx_parity_err(perr8), .rx_frame_err(ferr8),
    .tx_data(tx_data8), .tx_start(tx_start8), .tx_busy(busy8), .tx_done(done8));

  // 7E2 instance in permanent loopback
  logic       tx7, rx_valid7, perr7, ferr7, tx_start7, busy7, done7;
  logic [6:0] rx_data7, tx_data7;

  uart_param #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut7 (
    .clock(clk), .reset(reset), .rx(tx7), .tx(tx7), .rx_data(rx_data7),
    .rx_valid(rx_valid7), .rx_parity_err(perr7), .rx_frame_err(ferr7),
    .tx_data(tx_data7), .tx_start(tx_start7), .tx_busy(busy7), .tx_done(done7));

  // 8O1 instance, receive side driven by the bench
  logic       rxdO, txO, rx_validO, perrO, ferrO, busyO, doneO;
  logic [7:0] rx_dataO;

  uart_param #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dutO (
    .clock(clk), .reset(reset), .rx(rxdO), .tx(txO), .rx_data(rx_dataO),
    .rx_valid(rx_validO), .rx_parity_err(perrO), .rx_frame_err(ferrO),
    .tx_data(8'h00), .tx_start(1'b0), .tx_busy(busyO), .tx_done(doneO));

  // Pulse counters and captures, sampled 1 time unit after each rising edge
  int         v8 = 0, d8 = 0, v7 = 0, d7 = 0, vO = 0;
  logic [7:0] c8_data, cO_data;
  logic [6:0] c7_data;
  logic       c8_perr, c8_ferr, c7_perr, c7_ferr, cO_perr, cO_ferr;

  always @(posedge clk) begin
    #1;
    if (rx_valid8) begin v8++; c8_data = rx_data8; c8_perr = perr8; c8_ferr = ferr8; end
    if (rx_valid7) begin v7++; c7_data = rx_data7; c7_perr = perr7; c7_ferr = ferr7; end
    if (rx_validO) begin vO++; cO_data = rx_dataO; cO_perr = perrO; cO_ferr = ferrO; end
    if (done8) d8++;
    if (done7) d7++;
  end

  task automatic drive_line(input logic [15:0] bits, input int unsigned n, input bit sel_o);
    for (int unsigned i = 0; i < n; i++) begin
      if (sel_o) rxdO = bits[i];
      else       rxd8 = bits[i];
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx8 !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx8); end
    checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b%b exp=00", busy8, done8); end
    checks++; if (rx_valid8 !== 1'b0 || perr8 !== 1'b0 || ferr8 !== 1'b0) begin errors++; $display("FAIL reset_rx_flags got=%b%b%b exp=000", rx_valid8, perr8, ferr8); end
    checks++; if (rx_data8 !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%h exp=00", rx_data8); end
    checks++; if (tx7 !== 1'b1 || busy7 !== 1'b0 || txO !== 1'b1 || busyO !== 1'b0 || doneO !== 1'b0) begin
      errors++; $display("FAIL reset_other got tx7=%b busy7=%b txO=%b busyO=%b doneO=%b exp 1,0,1,0,0", tx7, busy7, txO, busyO, doneO);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tx_a5();
    logic [9:0] frame;
    frame = {1'b1, 8'hA5, 1'b0};
    d8 = 0;
    tx_data8 = 8'hA5; tx_start8 = 1'b1;
    @(negedge clk);
    tx_start8 = 1'b0;
    for (int k = 0; k < 100; k++) begin
      checks++;
      if (tx8 !== frame[k/10] || busy8 !== 1'b1) begin
        errors++; $display("FAIL tx_a5_line cycle=%0d got tx=%b busy=%b exp tx=%b busy=1", k, tx8, busy8, frame[k/10]);
      end
      @(negedge clk);
    end
    checks++; if (busy8 !== 1'b0 || done8 !== 1'b1 || tx8 !== 1'b1) begin
      errors++; $display("FAIL tx_a5_end got busy=%b done=%b tx=%b exp 0,1,1", busy8, done8, tx8);
    end
    repeat (10) @(negedge clk);
    checks++; if (d8 !== 1) begin errors++; $display("FAIL tx_a5_done_count got=%0d exp=1", d8); end
  endtask

  task automatic test_back_to_back();
    int n;
    d8 = 0;
    tx_data8 = 8'h3C; tx_start8 = 1'b1;
    @(negedge clk);
    tx_start8 = 1'b0;
    repeat (30) @(negedge clk);
    tx_data8 = 8'hFF; tx_start8 = 1'b1;
    @(negedge clk);
    tx_start8 = 1'b0;
    n = 0;
    while (done8 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++; if (n !== 69) begin errors++; $display("FAIL b2b_first_len got=%0d exp=69", n); end
    tx_data8 = 8'hC3; tx_start8 = 1'b1;
    @(negedge clk);
    tx_start8 = 1'b0;
    checks++; if (busy8 !== 1'b1 || tx8 !== 1'b0) begin errors++; $display("FAIL b2b_restart got busy=%b tx=%b exp 1,0", busy8, tx8); end
    repeat (15) @(negedge clk);
    checks++; if (tx8 !== 1'b1) begin errors++; $display("FAIL b2b_bit0 got=%b exp=1", tx8); end
    repeat (20) @(negedge clk);
    checks++; if (tx8 !== 1'b0) begin errors++; $display("FAIL b2b_bit2 got=%b exp=0", tx8); end
    n = 0;
    while (done8 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    repeat (30) @(negedge clk);
    checks++; if (busy8 !== 1'b0 || d8 !== 2) begin errors++; $display("FAIL b2b_no_queue got busy=%b dones=%0d exp 0,2", busy8, d8); end
  endtask

  task automatic test_loopback_7e2();
    int n;
    v7 = 0; d7 = 0;
    tx_data7 = 7'h41; tx_start7 = 1'b1;
    @(negedge clk);
    tx_start7 = 1'b0;
    n = 0;
    while (busy7 === 1'b1 && n < 300) begin n++; @(negedge clk); end
    checks++; if (n !== 110) begin errors++; $display("FAIL l7_busy_len got=%0d exp=110", n); end
    checks++; if (done7 !== 1'b1) begin errors++; $display("FAIL l7_done got=%b exp=1", done7); end
    repeat (20) @(negedge clk);
    checks++; if (v7 !== 1 || d7 !== 1) begin errors++; $display("FAIL l7_counts got valid=%0d done=%0d exp 1,1", v7, d7); end
    checks++; if (c7_data !== 7'h41 || c7_perr !== 1'b0 || c7_ferr !== 1'b0) begin
      errors++; $display("FAIL l7_rx got data=%h perr=%b ferr=%b exp 41,0,0", c7_data, c7_perr, c7_ferr);
    end
  endtask

  task automatic test_parity_odd();
    vO = 0;
    drive_line({5'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11, 1'b1);
    repeat (20) @(negedge clk);
    checks++; if (vO !== 1 || cO_data !== 8'h3C || cO_perr !== 1'b0 || cO_ferr !== 1'b0) begin
      errors++; $display("FAIL odd_good got n=%0d data=%h perr=%b ferr=%b exp 1,3c,0,0", vO, cO_data, cO_perr, cO_ferr);
    end
    vO = 0;
    drive_line({5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11, 1'b1);
    repeat (20) @(negedge clk);
    checks++; if (vO !== 1 || cO_data !== 8'h3C || cO_perr !== 1'b1 || cO_ferr !== 1'b0) begin
      errors++; $display("FAIL odd_bad got n=%0d data=%h perr=%b ferr=%b exp 1,3c,1,0", vO, cO_data, cO_perr, cO_ferr);
    end
  endtask

  task automatic test_glitch();
    v8 = 0;
    rxd8 = 1'b0;
    repeat (3) @(negedge clk);
    rxd8 = 1'b1;
    repeat (30) @(negedge clk);
    checks++; if (v8 !== 0) begin errors++; $display("FAIL glitch_reject got=%0d exp=0", v8); end
    drive_line({6'b0, 1'b1, 8'h55, 1'b0}, 10, 1'b0);
    repeat (20) @(negedge clk);
    checks++; if (v8 !== 1 || c8_data !== 8'h55 || c8_ferr !== 1'b0 || c8_perr !== 1'b0) begin
      errors++; $display("FAIL glitch_then_55 got n=%0d data=%h ferr=%b perr=%b exp 1,55,0,0", v8, c8_data, c8_ferr, c8_perr);
    end
  endtask

  task automatic test_break();
    v8 = 0;
    rxd8 = 1'b0;
    repeat (300) @(negedge clk);
    checks++; if (v8 !== 1 || c8_data !== 8'h00 || c8_ferr !== 1'b1) begin
      errors++; $display("FAIL break_frame got n=%0d data=%h ferr=%b exp 1,00,1", v8, c8_data, c8_ferr);
    end
    rxd8 = 1'b1;
    repeat (30) @(negedge clk);
    checks++; if (v8 !== 1 || ferr8 !== 1'b1) begin errors++; $display("FAIL break_release got n=%0d ferr=%b exp 1,1", v8, ferr8); end
  endtask

  task automatic test_reset_mid();
    int n;
    v8 = 0; d8 = 0; loop8 = 1'b0; rxd8 = 1'b1;
    tx_data8 = 8'h4A; tx_start8 = 1'b1;
    @(negedge clk);
    tx_start8 = 1'b0;
    for (int k = 1; k < 54; k++) begin
      if (k == 9) rxd8 = 1'b0;
      @(negedge clk);
    end
    checks++; if (busy8 !== 1'b1 || tx8 !== 1'b0) begin errors++; $display("FAIL rmid_pre got busy=%b tx=%b exp 1,0", busy8, tx8); end
    reset = 1'b1; rxd8 = 1'b1;
    @(negedge clk);
    checks++; if (tx8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0 || rx_valid8 !== 1'b0) begin
      errors++; $display("FAIL rmid_post got tx=%b busy=%b done=%b valid=%b exp 1,0,0,0", tx8, busy8, done8, rx_valid8);
    end
    checks++; if (ferr8 !== 1'b0 || rx_data8 !== 8'h00) begin errors++; $display("FAIL rmid_rx_clear got ferr=%b data=%h exp 0,00", ferr8, rx_data8); end
    reset = 1'b0;
    repeat (200) @(negedge clk);
    checks++; if (v8 !== 0 || d8 !== 0) begin errors++; $display("FAIL rmid_quiet got valid=%0d done=%0d exp 0,0", v8, d8); end
    loop8 = 1'b1;
    tx_data8 = 8'h81; tx_start8 = 1'b1;
    @(negedge clk);
    tx_start8 = 1'b0;
    n = 0;
    while (done8 !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    checks++; if (done8 !== 1'b1) begin errors++; $display("FAIL rmid_x81_timeout got done=%b exp=1", done8); end
    repeat (20) @(negedge clk);
    checks++; if (v8 !== 1 || c8_data !== 8'h81 || c8_ferr !== 1'b0 || d8 !== 1) begin
      errors++; $display("FAIL rmid_x81 got n=%0d data=%h ferr=%b dones=%0d exp 1,81,0,1", v8, c8_data, c8_ferr, d8);
    end
    loop8 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rxd8 = 1'b1; rxdO = 1'b1; loop8 = 1'b0;
    tx_start8 = 1'b0; tx_data8 = 8'h00; tx_start7 = 1'b0; tx_data7 = 7'h00;
    test_reset();
    test_tx_a5();
    test_back_to_back();
    test_loopback_7e2();
    test_parity_odd();
    test_glitch();
    test_break();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
